// File: rtl/bus_arbiter_param.sv
// rtl/bus_arbiter_param.sv - parameterised single-grant bus arbiter with grant timeout and utilisation counter
//
// Purpose:
//   Grants the shared bus to one of NUM_MASTERS requesters, either by fixed
//   priority (lowest index wins) or by round robin. A granted master must
//   start using the bus (bus_util=1) within 2^TIMEOUT_LEN cycles or the grant
//   is abandoned with a one-cycle timeout pulse. A saturating counter tracks
//   how many cycles the bus was in use.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   m_reqs       in   [NUM_MASTERS-1:0] per-master level request
//   bus_util     in   bus in use by the granted master
//   util_clr     in   synchronous clear of util_cycles (wins over increment)
//   m_grants     out  [NUM_MASTERS-1:0] registered one-hot-or-zero grant
//   mid_current  out  [MID_WIDTH-1:0] index of most recently granted master
//   state        out  [1:0] 0 IDLE, 1 GRANT, 2 BUSY
//   timeout      out  one-cycle pulse when a grant is abandoned
//   util_cycles  out  [UTIL_WIDTH-1:0] saturating count of bus_util cycles

module bus_arbiter_param #(
  parameter int NUM_MASTERS = 12,
  parameter int MID_WIDTH   = 4,
  parameter int TIMEOUT_LEN = 6,
  parameter int ARB_MODE    = 0,
  parameter int UTIL_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_reqs,
  input  logic                   bus_util,
  input  logic                   util_clr,
  output logic [NUM_MASTERS-1:0] m_grants,
  output logic [MID_WIDTH-1:0]   mid_current,
  output logic [1:0]             state,
  output logic                   timeout,
  output logic [UTIL_WIDTH-1:0]  util_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  localparam logic [MID_WIDTH-1:0] LAST_IDX = MID_WIDTH'(NUM_MASTERS - 1);

  state_t                   state_q;
  logic [TIMEOUT_LEN-1:0]   grant_cnt;
  logic [MID_WIDTH-1:0]     last_winner;

  logic [MID_WIDTH-1:0]     rr_start;
  logic [NUM_MASTERS-1:0]   rr_upper_mask;
  logic [NUM_MASTERS-1:0]   rr_upper_reqs;
  logic [MID_WIDTH-1:0]     fp_winner;
  logic [MID_WIDTH-1:0]     rr_winner;
  logic [MID_WIDTH-1:0]     winner;
  logic                     req_any;
  logic                     held_req;

  // Index of the lowest set bit; zero when the vector is empty (callers only
  // use the result when at least one bit is set).
  function automatic logic [MID_WIDTH-1:0] lowest_idx(input logic [NUM_MASTERS-1:0] v);
    logic [MID_WIDTH-1:0] r;
    r = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) r = MID_WIDTH'(i);
    end
    return r;
  endfunction

  assign req_any = |m_reqs;

  // The granted master's request, picked out through the one-hot grant so no
  // variable index into m_reqs is needed.
  assign held_req = |(m_reqs & m_grants);

  // Round robin: search starts one above the previous winner. Requests at or
  // above the start index take precedence; if none, wrap to the lowest request.
  always_comb begin
    rr_start      = (last_winner == LAST_IDX) ? '0 : last_winner + 1'b1;
    rr_upper_mask = ~((NUM_MASTERS'(1) << rr_start) - NUM_MASTERS'(1));
    rr_upper_reqs = m_reqs & rr_upper_mask;
    fp_winner     = lowest_idx(m_reqs);
    rr_winner     = (|rr_upper_reqs) ? lowest_idx(rr_upper_reqs) : fp_winner;
    winner        = (ARB_MODE == 1) ? rr_winner : fp_winner;
  end

  // Main FSM. All outputs are registered here; timeout defaults low so it can
  // only ever be a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      m_grants    <= '0;
      mid_current <= '0;
      timeout     <= 1'b0;
      grant_cnt   <= '0;
      last_winner <= LAST_IDX;
    end else begin
      timeout <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Never grant while someone is still driving the bus.
          if (!bus_util && req_any) begin
            m_grants    <= NUM_MASTERS'(1) << winner;
            mid_current <= winner;
            last_winner <= winner;
            grant_cnt   <= '0;
            state_q     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Order matters: bus use beats a withdrawn request and the timeout,
          // and a withdrawn request ends the grant without a timeout pulse.
          if (bus_util) begin
            state_q <= ST_BUSY;
          end else if (!held_req) begin
            m_grants <= '0;
            state_q  <= ST_IDLE;
          end else if (&grant_cnt) begin
            m_grants <= '0;
            timeout  <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            grant_cnt <= grant_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (!bus_util) begin
            m_grants <= '0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          m_grants <= '0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  // Utilisation counter: clear wins over increment, holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst || util_clr) begin
      util_cycles <= '0;
    end else if (bus_util && !(&util_cycles)) begin
      util_cycles <= util_cycles + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb/tb_bus_arbiter_param.sv - directed vector bench for bus_arbiter_param

module tb_bus_arbiter_param;

  logic        clk;
  logic        rst;
  logic [11:0] m_reqs;
  logic        bus_util;
  logic        util_clr;

  logic [11:0] a_grants;
  logic [3:0]  a_mid;
  logic [1:0]  a_state;
  logic        a_timeout;
  logic [3:0]  a_util;

  logic [11:0] b_grants;
  logic [3:0]  b_mid;
  logic [1:0]  b_state;
  logic        b_timeout;
  logic [15:0] b_util;

  int n_cmp  = 0;
  int n_fail = 0;

  // Fixed priority, short timeout, narrow utilisation counter.
  bus_arbiter_param #(
    .NUM_MASTERS(12), .MID_WIDTH(4), .TIMEOUT_LEN(4), .ARB_MODE(0), .UTIL_WIDTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .m_reqs(m_reqs), .bus_util(bus_util), .util_clr(util_clr),
    .m_grants(a_grants), .mid_current(a_mid), .state(a_state),
    .timeout(a_timeout), .util_cycles(a_util)
  );

  // Round robin with default timeout and counter width.
  bus_arbiter_param #(
    .NUM_MASTERS(12), .MID_WIDTH(4), .TIMEOUT_LEN(6), .ARB_MODE(1), .UTIL_WIDTH(16)
  ) dut_b (
    .clk(clk), .rst(rst), .m_reqs(m_reqs), .bus_util(bus_util), .util_clr(util_clr),
    .m_grants(b_grants), .mid_current(b_mid), .state(b_state),
    .timeout(b_timeout), .util_cycles(b_util)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [11:0] reqs;
    logic        bu;
    logic        clr;
    logic [11:0] g;
    logic [3:0]  mid;
    logic [1:0]  st;
    logic        to;
    logic [3:0]  util;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; m_reqs = '0; bus_util = 1'b0; util_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    logic early_to;
    int rr_exp[5];

    rst = 1'b1; m_reqs = '0; bus_util = 1'b0; util_clr = 1'b0;

    //             rst   reqs     bu    clr   grants   mid   st    to    util
    vecs[0]  = '{1'b1, 12'h034, 1'b0, 1'b0, 12'h000, 4'h0, 2'd0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 12'h034, 1'b0, 1'b0, 12'h004, 4'h2, 2'd1, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 12'h034, 1'b1, 1'b0, 12'h004, 4'h2, 2'd2, 1'b0, 4'd1};
    vecs[3]  = '{1'b0, 12'h034, 1'b1, 1'b0, 12'h004, 4'h2, 2'd2, 1'b0, 4'd2};
    vecs[4]  = '{1'b0, 12'h034, 1'b1, 1'b0, 12'h004, 4'h2, 2'd2, 1'b0, 4'd3};
    vecs[5]  = '{1'b0, 12'h034, 1'b0, 1'b0, 12'h000, 4'h2, 2'd0, 1'b0, 4'd3};
    vecs[6]  = '{1'b0, 12'h030, 1'b0, 1'b0, 12'h010, 4'h4, 2'd1, 1'b0, 4'd3};
    vecs[7]  = '{1'b0, 12'h030, 1'b1, 1'b0, 12'h010, 4'h4, 2'd2, 1'b0, 4'd4};
    vecs[8]  = '{1'b0, 12'h030, 1'b0, 1'b0, 12'h000, 4'h4, 2'd0, 1'b0, 4'd4};
    vecs[9]  = '{1'b0, 12'h030, 1'b1, 1'b0, 12'h000, 4'h4, 2'd0, 1'b0, 4'd5};
    vecs[10] = '{1'b0, 12'h030, 1'b0, 1'b0, 12'h010, 4'h4, 2'd1, 1'b0, 4'd5};
    vecs[11] = '{1'b0, 12'h020, 1'b0, 1'b0, 12'h000, 4'h4, 2'd0, 1'b0, 4'd5};
    vecs[12] = '{1'b0, 12'h020, 1'b0, 1'b0, 12'h020, 4'h5, 2'd1, 1'b0, 4'd5};
    vecs[13] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 4'h5, 2'd0, 1'b0, 4'd5};
    vecs[14] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 4'h5, 2'd0, 1'b0, 4'd5};
    vecs[15] = '{1'b0, 12'h801, 1'b0, 1'b0, 12'h001, 4'h0, 2'd1, 1'b0, 4'd5};
    vecs[16] = '{1'b0, 12'h801, 1'b1, 1'b0, 12'h001, 4'h0, 2'd2, 1'b0, 4'd6};
    vecs[17] = '{1'b0, 12'h801, 1'b1, 1'b0, 12'h001, 4'h0, 2'd2, 1'b0, 4'd7};
    vecs[18] = '{1'b1, 12'h801, 1'b1, 1'b0, 12'h000, 4'h0, 2'd0, 1'b0, 4'd0};
    vecs[19] = '{1'b0, 12'h800, 1'b0, 1'b0, 12'h800, 4'hb, 2'd1, 1'b0, 4'd0};
    vecs[20] = '{1'b0, 12'h800, 1'b1, 1'b1, 12'h800, 4'hb, 2'd2, 1'b0, 4'd0};
    vecs[21] = '{1'b0, 12'h800, 1'b0, 1'b0, 12'h000, 4'hb, 2'd0, 1'b0, 4'd0};

    // Fixed-priority table on dut_a.
    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; m_reqs = vecs[i].reqs; bus_util = vecs[i].bu; util_clr = vecs[i].clr;
      step();
      chk($sformatf("v%0d_grants", i), a_grants, vecs[i].g);
      chk($sformatf("v%0d_mid", i), a_mid, vecs[i].mid);
      chk($sformatf("v%0d_state", i), a_state, vecs[i].st);
      chk($sformatf("v%0d_timeout", i), a_timeout, vecs[i].to);
      chk($sformatf("v%0d_util", i), a_util, vecs[i].util);
      chk($sformatf("v%0d_onehot", i), $onehot0(a_grants), 1);
    end

    // Round robin from reset: first search starts at 0, then wraps 11 -> 0.
    do_reset();
    chk("rr_reset_grants", b_grants, 12'h000);
    chk("rr_reset_mid", b_mid, 4'h0);
    m_reqs = 12'h801; step();
    chk("rr_first_grant", b_grants, 12'h001);
    m_reqs = 12'h000; step();
    chk("rr_release_state", b_state, 2'd0);
    m_reqs = 12'h801; step();
    chk("rr_second_grant", b_grants, 12'h800);
    chk("rr_second_mid", b_mid, 4'hb);
    m_reqs = 12'h000; step();
    m_reqs = 12'h801; step();
    chk("rr_wrap_grant", b_grants, 12'h001);
    m_reqs = 12'h000; step();

    // Round robin with 12'h034 held, each grant completed by a 2-cycle bus pulse.
    rr_exp = '{2, 4, 5, 2, 4};
    do_reset();
    m_reqs = 12'h034;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr_seq%0d_grants", k), b_grants, 12'h001 << rr_exp[k]);
      chk($sformatf("rr_seq%0d_mid", k), b_mid, rr_exp[k]);
      chk($sformatf("rr_seq%0d_state", k), b_state, 2'd1);
      bus_util = 1'b1;
      step();
      step();
      chk($sformatf("rr_seq%0d_busy", k), b_state, 2'd2);
      bus_util = 1'b0;
      step();
      chk($sformatf("rr_seq%0d_release", k), b_grants, 12'h000);
    end

    // Timeout on dut_a (16 grant cycles), then re-grant, then reset mid-GRANT.
    do_reset();
    m_reqs = 12'h020;
    step();
    gcnt = 0; early_to = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (a_grants == 12'h020 && a_state == 2'd1) gcnt++;
      if (a_timeout) early_to = 1'b1;
      step();
    end
    chk("to_grant_cycles", gcnt, 16);
    chk("to_no_early_pulse", early_to, 1'b0);
    chk("to_pulse", a_timeout, 1'b1);
    chk("to_state_idle", a_state, 2'd0);
    chk("to_grant_dropped", a_grants, 12'h000);
    step();
    chk("to_pulse_single", a_timeout, 1'b0);
    chk("to_regrant", a_grants, 12'h020);
    chk("to_regrant_state", a_state, 2'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_grant_grants", a_grants, 12'h000);
    chk("rst_grant_state", a_state, 2'd0);
    chk("rst_grant_mid", a_mid, 4'h0);

    // bus_util rises on the 16th GRANT cycle: BUSY wins, no timeout.
    do_reset();
    m_reqs = 12'h020;
    step();
    early_to = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (a_timeout) early_to = 1'b1;
      step();
    end
    bus_util = 1'b1;
    step();
    chk("race_state_busy", a_state, 2'd2);
    chk("race_no_timeout", a_timeout | early_to, 1'b0);
    chk("race_grant_held", a_grants, 12'h020);
    bus_util = 1'b0;
    step();
    chk("race_release_state", a_state, 2'd0);
    chk("race_release_timeout", a_timeout, 1'b0);

    // Saturation of the 4-bit utilisation counter, then clear.
    do_reset();
    bus_util = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("util_at_15", a_util, 4'd15);
    for (int i = 0; i < 5; i++) step();
    chk("util_saturated", a_util, 4'd15);
    chk("util_no_grant", a_grants, 12'h000);
    util_clr = 1'b1;
    step();
    chk("util_cleared", a_util, 4'd0);
    util_clr = 1'b0; bus_util = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_param.md
BUS_ARBITER_PARAM -- requirements
Module: bus_arbiter_param

Interface
REQ-001 Parameter NUM_MASTERS, default 12, number of requesting masters (2..16).
REQ-002 Parameter MID_WIDTH, default 4, width of master ID; SHALL satisfy 2^MID_WIDTH >= NUM_MASTERS.
REQ-003 Parameter TIMEOUT_LEN, default 6, grant-acknowledge timeout counter width in bits (timeout = 2^TIMEOUT_LEN cycles).
REQ-004 Parameter ARB_MODE, default 0, arbitration mode: 0 = fixed priority, 1 = round robin.
REQ-005 Parameter UTIL_WIDTH, default 16, width of the utilisation counter.
REQ-006 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-007 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port m_reqs, input, NUM_MASTERS, per-master bus request, level.
REQ-010 Port bus_util, input, 1, bus-utilising line driven by the granted master.
REQ-011 Port util_clr, input, 1, synchronous clear of util_cycles.
REQ-012 Port m_grants, output, NUM_MASTERS, one-hot or zero grant vector, registered.
REQ-013 Port mid_current, output, MID_WIDTH, index of the most recently granted master.
REQ-014 Port state, output, 2, FSM state: 0 IDLE, 1 GRANT, 2 BUSY.
REQ-015 Port timeout, output, 1, single-cycle pulse on grant abandonment.
REQ-016 Port util_cycles, output, UTIL_WIDTH, saturating count of cycles with bus_util=1.

Function
REQ-017 m_grants SHALL never have more than one bit set.
REQ-018 IDLE: when bus_util=0 and m_reqs!=0, the winner's grant bit SHALL be set on the next edge, with mid_current=winner and state=GRANT; no grant issues while bus_util=1.
REQ-019 ARB_MODE=0: winner is the lowest-index asserted request.
REQ-020 ARB_MODE=1: winner is the first asserted request at or after index (last_winner+1), searching upward and wrapping from NUM_MASTERS-1 to 0.
REQ-021 Round-robin pointer last_winner SHALL update on every grant issue, including grants that later time out.
REQ-022 GRANT: if bus_util=1, next state BUSY with grant held.
REQ-023 GRANT: if bus_util=0 and the granted master's request is low, the grant clears and next state is IDLE, with no timeout pulse.
REQ-024 GRANT: a cycle counter, cleared on entry, increments each GRANT cycle; when it reaches 2^TIMEOUT_LEN-1 with bus_util=0, the grant clears, timeout pulses for 1 cycle and next state is IDLE.
REQ-025 If bus_util rises in the same cycle the timeout count is reached, BUSY SHALL win and no timeout pulse occurs.
REQ-026 BUSY: grant held while bus_util=1; on bus_util=0, the grant clears on the next edge and state returns to IDLE, regardless of m_reqs.
REQ-027 Grant latency from request (bus idle) SHALL be 1 cycle; IDLE to IDLE re-arbitration gap SHALL be at least 1 cycle.
REQ-028 util_cycles increments by 1 each cycle bus_util=1 and saturates at all-ones; util_clr has priority over increment.
REQ-029 mid_current SHALL hold its value outside grant issue.

Reset
REQ-030 With rst=1 at an edge: m_grants=0, mid_current=0, state=IDLE, timeout=0, util_cycles=0, timeout counter=0, last_winner=NUM_MASTERS-1 (first RR search starts at 0).
REQ-031 rst SHALL dominate all other inputs, including mid-BUSY and mid-GRANT; any held grant drops on the reset edge.

Verification
REQ-032 Fixed priority: ARB_MODE=0, m_reqs=12'h034 held, bus idle -> m_grants=12'h004, mid_current=2 one cycle later; after bus_util pulses high 3 cycles then low -> grant drops; master 2 releases request -> next grant 12'h010.
REQ-033 Round robin: ARB_MODE=1, m_reqs=12'h034 constant, each grant completed by a 2-cycle bus_util pulse -> grant sequence 2,4,5,2,4.
REQ-034 Timeout: TIMEOUT_LEN=4, m_reqs=12'h020, bus_util held 0 -> grant 12'h020 for exactly 16 cycles, then timeout=1 for one cycle and state=IDLE; re-grant follows one cycle later.
REQ-035 Race: bus_util rises on the 16th GRANT cycle -> state=BUSY, timeout stays 0.
REQ-036 Reset mid-BUSY: rst=1 while BUSY with util_cycles=7 -> next cycle all outputs at REQ-030 values; UTIL_WIDTH=4 with 20 cycles of bus_util=1 -> util_cycles=15, then util_clr -> 0.
